// File: rtl/data_memory_arbiter_if.sv
// Bus bundle between the MEM-stage requester, the debug/loader port,
// the data RAM and the arbiter.
//   cpu_*    : MEM-stage request (req/we/addr/wdata in, rdata/stall out)
//   dbg_*    : debug/loader request (req/we/addr/wdata in, rdata/ack out)
//   mem_*    : DataMemory side (word addr, wdata, we, re out; rdata in)
//   addr_err : one-cycle pulse after an illegal granted access
// Modport slave is the arbiter's view; master is the surrounding system.
interface data_memory_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;

  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic [31:0] dbg_rdata;
  logic        dbg_ack;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rdata;

  logic        addr_err;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_addr, mem_wdata, mem_we, mem_re,
    input  mem_rdata,
    output addr_err
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_addr, mem_wdata, mem_we, mem_re,
    output mem_rdata,
    input  addr_err
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// Arbitrates the single-port data RAM between the pipeline MEM stage
// (zero-latency, stalled when it loses) and a debug/loader port (ack one
// cycle after its grant). Byte addresses are rebased to RAM word indices;
// misaligned or out-of-range accesses are suppressed and flagged.
// Ports: clk, reset (synchronous, active-high), bus (slave modport of
// data_memory_arbiter_if carrying the cpu_*, dbg_*, mem_* and addr_err signals).
module data_memory_arbiter #(
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] DATA_BASE    = 32'h1001_0000,
  parameter int unsigned MAX_WAIT     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  data_memory_arbiter_if.slave bus
);

  localparam int unsigned      CNT_W       = 4;
  localparam logic [CNT_W-1:0] WAIT_LIMIT  = CNT_W'(MAX_WAIT);
  localparam logic [31:0]      RANGE_BYTES = 32'(MEMORY_DEPTH * 4);

  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             dbg_ack_q;
  logic [31:0]      dbg_rdata_q;
  logic             addr_err_q;

  logic             dbg_eligible;
  logic             dbg_grant;
  logic             cpu_grant;
  logic             any_grant;
  logic             sel_we;
  logic [31:0]      sel_addr;
  logic [31:0]      off;
  logic             legal;
  logic [31:0]      rd_data;

  // Per-cycle grant, address translation and next-state for the wait counter.
  always_comb begin
    dbg_eligible  = 1'b0;
    dbg_grant     = 1'b0;
    cpu_grant     = 1'b0;
    any_grant     = 1'b0;
    sel_we        = 1'b0;
    sel_addr      = '0;
    off           = '0;
    legal         = 1'b0;
    rd_data       = '0;
    wait_cnt_nxt  = wait_cnt;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    bus.cpu_rdata = '0;
    bus.cpu_stall = 1'b0;

    // A request still high during its own ack cycle is the old one.
    dbg_eligible = bus.dbg_req & ~dbg_ack_q;
    // Reset suppresses every grant so nothing reaches the RAM.
    dbg_grant = ~reset & dbg_eligible & (~bus.cpu_req | (wait_cnt == WAIT_LIMIT));
    cpu_grant = ~reset & bus.cpu_req & ~dbg_grant;
    any_grant = dbg_grant | cpu_grant;

    sel_addr = dbg_grant ? bus.dbg_addr : bus.cpu_addr;
    sel_we   = dbg_grant ? bus.dbg_we   : bus.cpu_we;
    // Wrapping subtraction makes addresses below the base huge, hence out of range.
    off      = sel_addr - DATA_BASE;
    legal    = (off < RANGE_BYTES) && (sel_addr[1:0] == 2'b00);

    if (any_grant && legal) begin
      bus.mem_addr  = off >> 2;
      bus.mem_wdata = dbg_grant ? bus.dbg_wdata : bus.cpu_wdata;
      bus.mem_we    = sel_we;
      bus.mem_re    = ~sel_we;
      if (!sel_we) begin
        rd_data = bus.mem_rdata;
      end
    end

    if (cpu_grant) begin
      bus.cpu_rdata = rd_data;
    end
    bus.cpu_stall = ~reset & bus.cpu_req & ~cpu_grant;

    // Starvation counter: counts only cycles a live debug request loses.
    if (!dbg_eligible || dbg_grant) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != WAIT_LIMIT) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end
  end

  // Registered state: wait counter, debug completion and error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt    <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      wait_cnt   <= wait_cnt_nxt;
      dbg_ack_q  <= dbg_grant;
      addr_err_q <= any_grant & ~legal;
      if (dbg_grant) begin
        dbg_rdata_q <= rd_data;
      end
    end
  end

  assign bus.dbg_ack   = dbg_ack_q;
  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed bench for data_memory_arbiter with a small word RAM attached.
module tb_data_memory_arbiter;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  data_memory_arbiter_if bus();

  data_memory_arbiter #(
    .MEMORY_DEPTH(64),
    .DATA_BASE   (32'h1001_0000),
    .MAX_WAIT    (4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Asynchronous-read RAM, write at clock edge; word 63 holds a marker.
  logic [31:0] ram [64];
  assign bus.mem_rdata = ram[bus.mem_addr[5:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) ram[i] <= 32'h0;
      ram[63] <= 32'hA5A5_0063;
    end else if (bus.mem_we) begin
      ram[bus.mem_addr[5:0]] <= bus.mem_wdata;
    end
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
    bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      bus.cpu_req = 1'($urandom); bus.cpu_we = 1'($urandom);
      bus.cpu_addr = 32'h1001_0000 | 32'($urandom_range(0, 63) * 4);
      bus.cpu_wdata = $urandom;
      bus.dbg_req = 1'($urandom); bus.dbg_we = 1'($urandom);
      bus.dbg_addr = 32'h1001_0000 | 32'($urandom_range(0, 63) * 4);
      bus.dbg_wdata = $urandom;
      #1;
      checks++;
      if ({bus.mem_we, bus.mem_re, bus.cpu_stall} !== 3'b000 || bus.mem_addr !== 32'h0 ||
          bus.cpu_rdata !== 32'h0 || bus.mem_wdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_comb c%0d: we/re/stall=%b addr=%h rdata=%h wdata=%h expected all 0",
                 c, {bus.mem_we, bus.mem_re, bus.cpu_stall}, bus.mem_addr, bus.cpu_rdata, bus.mem_wdata);
      end
      step();
      checks++;
      if (bus.dbg_ack !== 1'b0 || bus.dbg_rdata !== 32'h0 || bus.addr_err !== 1'b0 ||
          dut.wait_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_regs c%0d: ack=%b rdata=%h err=%b wait=%0d expected 0",
                 c, bus.dbg_ack, bus.dbg_rdata, bus.addr_err, dut.wait_cnt);
      end
    end
    reset = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_re, bus.cpu_stall, bus.dbg_ack, bus.addr_err} !== 5'b0 ||
        bus.mem_addr !== 32'h0 || bus.cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_outputs: flags=%b addr=%h rdata=%h expected 0",
               {bus.mem_we, bus.mem_re, bus.cpu_stall, bus.dbg_ack, bus.addr_err},
               bus.mem_addr, bus.cpu_rdata);
    end
  endtask

  task automatic test_cpu_write_read();
    bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_addr = 32'h1001_0008; bus.cpu_wdata = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (bus.mem_addr !== 32'd2 || bus.mem_we !== 1'b1 || bus.mem_re !== 1'b0 ||
        bus.cpu_stall !== 1'b0 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL cpu_write: addr=%h we=%b re=%b stall=%b wdata=%h expected 2 1 0 0 deadbeef",
               bus.mem_addr, bus.mem_we, bus.mem_re, bus.cpu_stall, bus.mem_wdata);
    end
    step();
    bus.cpu_we = 0;
    #1;
    checks++;
    if (bus.cpu_rdata !== 32'hDEAD_BEEF || bus.mem_re !== 1'b1 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL cpu_read: rdata=%h re=%b we=%b expected deadbeef 1 0",
               bus.cpu_rdata, bus.mem_re, bus.mem_we);
    end
    step();
    bus.cpu_req = 0;
    checks++;
    if (bus.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL cpu_legal_no_err: addr_err=%b expected 0", bus.addr_err);
    end
  endtask

  task automatic test_debug_only();
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h1001_000C; bus.dbg_wdata = 32'h1234_5678;
    #1;
    checks++;
    if (bus.mem_addr !== 32'd3 || bus.mem_we !== 1'b1 || bus.dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_write_c0: addr=%h we=%b ack=%b expected 3 1 0",
               bus.mem_addr, bus.mem_we, bus.dbg_ack);
    end
    step();
    #1;
    checks++;
    if (bus.dbg_ack !== 1'b1 || bus.mem_we !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
      errors++;
      $display("FAIL dbg_write_c1: ack=%b we=%b rdata=%h expected 1 0 0",
               bus.dbg_ack, bus.mem_we, bus.dbg_rdata);
    end
    bus.dbg_req = 0;
    step();
    checks++;
    if (bus.dbg_ack !== 1'b0) begin
      errors++;
      $display("FAIL dbg_ack_single: ack=%b expected 0", bus.dbg_ack);
    end
    bus.dbg_req = 1; bus.dbg_we = 0;
    #1;
    checks++;
    if (bus.mem_re !== 1'b1 || bus.mem_addr !== 32'd3) begin
      errors++;
      $display("FAIL dbg_read_c0: re=%b addr=%h expected 1 3", bus.mem_re, bus.mem_addr);
    end
    step();
    checks++;
    if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL dbg_read_c1: ack=%b rdata=%h expected 1 12345678", bus.dbg_ack, bus.dbg_rdata);
    end
    bus.dbg_req = 0;
    step();
  endtask

  task automatic test_contention();
    logic [31:0] exp_addr;
    logic [31:0] exp_cpu;
    logic [3:0]  exp_wait;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h1001_0008;
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h1001_000C;
    for (int c = 0; c < 6; c++) begin
      #1;
      exp_addr = (c == 4) ? 32'd3 : 32'd2;
      exp_cpu  = (c == 4) ? 32'h0 : 32'hDEAD_BEEF;
      exp_wait = (c <= 4) ? 4'(c) : 4'd0;
      checks++;
      if (bus.cpu_stall !== (c == 4) || bus.dbg_ack !== (c == 5) || bus.mem_addr !== exp_addr ||
          bus.cpu_rdata !== exp_cpu || dut.wait_cnt !== exp_wait) begin
        errors++;
        $display("FAIL contention c%0d: stall=%b ack=%b addr=%h rdata=%h wait=%0d expected %b %b %h %h %0d",
                 c, bus.cpu_stall, bus.dbg_ack, bus.mem_addr, bus.cpu_rdata, dut.wait_cnt,
                 (c == 4), (c == 5), exp_addr, exp_cpu, exp_wait);
      end
      if (c == 5) begin
        checks++;
        if (bus.dbg_rdata !== 32'h1234_5678) begin
          errors++;
          $display("FAIL contention_rdata: rdata=%h expected 12345678", bus.dbg_rdata);
        end
      end
      step();
    end
    idle_inputs();
    step();
  endtask

  task automatic test_illegal();
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h1001_0100;
    #1;
    checks++;
    if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0 || bus.cpu_rdata !== 32'h0 || bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL ill_range: re=%b we=%b rdata=%h stall=%b expected 0 0 0 0",
               bus.mem_re, bus.mem_we, bus.cpu_rdata, bus.cpu_stall);
    end
    step();
    checks++;
    if (bus.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL ill_range_err: addr_err=%b expected 1", bus.addr_err);
    end
    bus.cpu_we = 1; bus.cpu_addr = 32'h1001_0002; bus.cpu_wdata = 32'hBAD0_0001;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL ill_misalign_we: mem_we=%b expected 0", bus.mem_we);
    end
    step();
    bus.cpu_we = 0; bus.cpu_addr = 32'h0FFF_FFFC;
    checks++;
    if (bus.addr_err !== 1'b1 || ram[0] !== 32'h0) begin
      errors++;
      $display("FAIL ill_misalign_err: addr_err=%b ram0=%h expected 1 0", bus.addr_err, ram[0]);
    end
    #1;
    checks++;
    if (bus.cpu_rdata !== 32'h0 || bus.mem_re !== 1'b0) begin
      errors++;
      $display("FAIL ill_below: rdata=%h re=%b expected 0 0", bus.cpu_rdata, bus.mem_re);
    end
    step();
    checks++;
    if (bus.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL ill_below_err: addr_err=%b expected 1", bus.addr_err);
    end
    // Last legal word of the segment.
    bus.cpu_addr = 32'h1001_00FC;
    #1;
    checks++;
    if (bus.mem_addr !== 32'd63 || bus.mem_re !== 1'b1 || bus.cpu_rdata !== 32'hA5A5_0063) begin
      errors++;
      $display("FAIL top_word: addr=%h re=%b rdata=%h expected 3f 1 a5a50063",
               bus.mem_addr, bus.mem_re, bus.cpu_rdata);
    end
    step();
    bus.cpu_req = 0;
    checks++;
    if (bus.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL top_word_err: addr_err=%b expected 0", bus.addr_err);
    end
    // Illegal debug read still acks with zero data.
    bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 32'h0FFF_FFFC;
    step();
    checks++;
    if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 32'h0 || bus.addr_err !== 1'b1) begin
      errors++;
      $display("FAIL dbg_illegal: ack=%b rdata=%h err=%b expected 1 0 1",
               bus.dbg_ack, bus.dbg_rdata, bus.addr_err);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_reset_mid_debug();
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 32'h1001_0010; bus.dbg_wdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 32'd4) begin
      errors++;
      $display("FAIL rst_dbg_c0: we=%b addr=%h expected 1 4", bus.mem_we, bus.mem_addr);
    end
    step();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_dbg_c1_we: mem_we=%b expected 0", bus.mem_we);
    end
    step();
    reset = 1'b0;
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h1001_0000;
    #1;
    checks++;
    if (bus.dbg_ack !== 1'b0 || dut.wait_cnt !== 4'd0 || bus.cpu_stall !== 1'b0) begin
      errors++;
      $display("FAIL rst_dbg_c2: ack=%b wait=%0d stall=%b expected 0 0 0",
               bus.dbg_ack, dut.wait_cnt, bus.cpu_stall);
    end
    step();
    checks++;
    if (bus.dbg_ack !== 1'b0 || dut.wait_cnt !== 4'd1) begin
      errors++;
      $display("FAIL rst_dbg_c3: ack=%b wait=%0d expected 0 1", bus.dbg_ack, dut.wait_cnt);
    end
    idle_inputs();
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    idle_inputs();
    test_reset();
    test_cpu_write_read();
    test_debug_only();
    test_contention();
    test_illegal();
    test_reset_mid_debug();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
